// File: rtl/capture_seq_pkg.sv
// capture_seq_pkg
//   Shared definitions for the capture sequencer: FSM state encoding,
//   counter widths and the default values of the top-level parameters.
package capture_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SYNC    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int BYTE_CNT_W  = 15;
    localparam int FRAME_CNT_W = 16;

    localparam int DEF_SKIP_FRAMES    = 1;
    localparam int DEF_FRAME_BYTES    = 19200;
    localparam int DEF_TIMEOUT_CYCLES = 24000000;

endpackage

// File: rtl/vsync_edge_detect.sv
// vsync_edge_detect
//   Keeps a one-cycle registered copy of vsync and compares the live level
//   against it to produce single-cycle rise/fall pulses.
//
// Ports
//   clock_i  in   system clock, rising edge
//   reset_i  in   synchronous active-high reset, clears the registered copy
//   vsync_i  in   frame-active level
//   rise_o   out  1 in the first cycle vsync is seen high
//   fall_o   out  1 in the first cycle vsync is seen low
module vsync_edge_detect (
    input  logic clock_i,
    input  logic reset_i,
    input  logic vsync_i,
    output logic rise_o,
    output logic fall_o
);

    logic vsync_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
        end
    end

    assign rise_o = vsync_i & ~vsync_q;
    assign fall_o = ~vsync_i & vsync_q;

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Gates a camera pixel byte stream so that exactly one whole frame is
//   forwarded per arm request (or per frame slot in continuous mode), after
//   discarding SKIP_FRAMES complete frames. Bytes beyond FRAME_BYTES in a
//   frame are dropped.
//
//   Optional build macro: CAPTURE_SEQ_TIMEOUT_EN adds a watchdog that aborts
//   SYNC/CAPTURE after TIMEOUT_CYCLES cycles and raises a sticky timeout.
//   Without it, timeout is tied low and no watchdog counter exists.
//
// Ports
//   clock           in   system clock, rising edge
//   reset           in   synchronous active-high reset
//   init_busy       in   camera init sequencer busy level
//   arm             in   single-shot capture request (level)
//   continuous      in   re-arm automatically after each frame
//   vsync           in   frame-active level (rise = start, fall = end)
//   data_in_valid   in   pixel byte strobe
//   data_in[7:0]    in   pixel byte
//   buf_ready       in   output buffer can take a full frame
//   data_out_valid  out  gated pixel strobe, 1 cycle after data_in_valid
//   data_out[7:0]   out  gated pixel byte, 0 when not valid
//   capturing       out  high while in CAPTURE
//   frame_done      out  one-cycle pulse per completed captured frame
//   timeout         out  sticky watchdog flag
//   frame_count     out  completed captured frames, wraps
//   byte_count      out  bytes forwarded in current/last frame, saturating
module capture_sequencer
    import capture_seq_pkg::*;
#(
    parameter int SKIP_FRAMES    = DEF_SKIP_FRAMES,
    parameter int FRAME_BYTES    = DEF_FRAME_BYTES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        init_busy,
    input  logic        arm,
    input  logic        continuous,
    input  logic        vsync,
    input  logic        data_in_valid,
    input  logic [7:0]  data_in,
    input  logic        buf_ready,
    output logic        data_out_valid,
    output logic [7:0]  data_out,
    output logic        capturing,
    output logic        frame_done,
    output logic        timeout,
    output logic [15:0] frame_count,
    output logic [14:0] byte_count
);

    localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [SKIP_W-1:0]     SKIP_LOAD   = SKIP_W'(SKIP_FRAMES);
    localparam logic [BYTE_CNT_W-1:0] BYTE_LIMIT  = BYTE_CNT_W'(FRAME_BYTES);

    state_e                   state_q;
    logic                     busy_seen_q;
    logic                     in_frame_q;
    logic [SKIP_W-1:0]        skip_q;
    logic [BYTE_CNT_W-1:0]    byte_cnt_q;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q;
    logic                     dout_vld_q;
    logic [7:0]               dout_q;
    logic                     capturing_q;
    logic                     frame_done_q;
    logic                     vs_rise;
    logic                     vs_fall;

    vsync_edge_detect u_vsync_edge (
        .clock_i (clock),
        .reset_i (reset),
        .vsync_i (vsync),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            busy_seen_q  <= 1'b0;
            in_frame_q   <= 1'b0;
            skip_q       <= '0;
            byte_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            dout_vld_q   <= 1'b0;
            dout_q       <= '0;
            capturing_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
            wd_q         <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            // Output strobes default low; data_out is forced to 0 when idle.
            frame_done_q <= 1'b0;
            dout_vld_q   <= 1'b0;
            dout_q       <= '0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
            if (state_q == ST_SYNC || state_q == ST_CAPTURE) begin
                wd_q <= wd_q + WD_W'(1);
            end
`endif
            case (state_q)
                ST_INIT: begin
                    // Leave only after a full busy high->low cycle.
                    if (init_busy) begin
                        busy_seen_q <= 1'b1;
                    end else if (busy_seen_q) begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if ((arm || continuous) && buf_ready) begin
                        state_q    <= ST_SYNC;
                        skip_q     <= SKIP_LOAD;
                        // A frame already running at entry has no rise seen
                        // here, so its falling edge is ignored below.
                        in_frame_q <= 1'b0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                        wd_q       <= '0;
`endif
                    end
                end

                ST_SYNC: begin
                    if (vs_rise) begin
                        if (skip_q == '0) begin
                            state_q     <= ST_CAPTURE;
                            capturing_q <= 1'b1;
                            byte_cnt_q  <= '0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                            wd_q        <= '0;
`endif
                        end else begin
                            in_frame_q <= 1'b1;
                        end
                    end else if (vs_fall && in_frame_q) begin
                        in_frame_q <= 1'b0;
                        skip_q     <= skip_q - SKIP_W'(1);
                    end
                end

                ST_CAPTURE: begin
                    // A byte on the frame-end cycle is still forwarded.
                    if (data_in_valid && (byte_cnt_q < BYTE_LIMIT)) begin
                        dout_vld_q <= 1'b1;
                        dout_q     <= data_in;
                        byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(1);
                    end
                    if (vs_fall) begin
                        state_q      <= ST_DONE;
                        capturing_q  <= 1'b0;
                        frame_done_q <= 1'b1;
                        frame_cnt_q  <= frame_cnt_q + FRAME_CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_INIT;
                end
            endcase
`ifdef CAPTURE_SEQ_TIMEOUT_EN
            // Watchdog expiry overrides any transition decided above,
            // including a frame end on the same cycle.
            if ((state_q == ST_SYNC || state_q == ST_CAPTURE) && (wd_q == WD_LAST)) begin
                timeout_q    <= 1'b1;
                state_q      <= ST_IDLE;
                capturing_q  <= 1'b0;
                frame_done_q <= 1'b0;
                frame_cnt_q  <= frame_cnt_q;
            end
`endif
        end
    end

    assign data_out_valid = dout_vld_q;
    assign data_out       = dout_q;
    assign capturing      = capturing_q;
    assign frame_done     = frame_done_q;
    assign frame_count    = frame_cnt_q;
    assign byte_count     = byte_cnt_q;

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // Watchdog compiled out: the flag is a constant low.
    assign timeout = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
module tb_capture_sequencer;

    localparam int SKIP = 1;
    localparam int FB   = 64;
    localparam int TO   = 1000;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        init_busy = 1'b0;
    logic        arm = 1'b0;
    logic        continuous = 1'b0;
    logic        vsync = 1'b0;
    logic        data_in_valid = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic        buf_ready = 1'b1;
    logic        data_out_valid;
    logic [7:0]  data_out;
    logic        capturing;
    logic        frame_done;
    logic        timeout;
    logic [15:0] frame_count;
    logic [14:0] byte_count;

    always #5 clock = ~clock;

    capture_sequencer #(
        .SKIP_FRAMES    (SKIP),
        .FRAME_BYTES    (FB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .init_busy      (init_busy),
        .arm            (arm),
        .continuous     (continuous),
        .vsync          (vsync),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .buf_ready      (buf_ready),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .capturing      (capturing),
        .frame_done     (frame_done),
        .timeout        (timeout),
        .frame_count    (frame_count),
        .byte_count     (byte_count)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int bytes;
        int fcount;
    } frame_t;

    logic [7:0] byte_q[$];
    frame_t     frame_q[$];

    // Reference model: armed flag, frames still to skip, completed frames.
    bit m_armed = 1'b0;
    int m_skip  = 0;
    int m_fc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_arm();
        m_armed = 1'b1;
        m_skip  = SKIP;
    endtask

    function automatic bit model_frame_start();
        if (!m_armed) return 1'b0;
        if (m_skip > 0) begin
            m_skip--;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_frame_done(input int n);
        frame_t f;
        m_fc     = (m_fc + 1) % 65536;
        f.bytes  = n;
        f.fcount = m_fc;
        frame_q.push_back(f);
        m_armed = continuous && buf_ready;
        m_skip  = SKIP;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        model_arm();
        repeat (3) tick();
        arm = 1'b0;
    endtask

    task automatic init_seq();
        init_busy = 1'b1;
        repeat (10) tick();
        init_busy = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_frame(input int n);
        bit cap;
        int fwd;
        fwd = 0;
        cap = model_frame_start();
        vsync = 1'b1;
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                data_in_valid = 1'b0;
                data_in = 8'($urandom);
                tick();
            end
            data_in = 8'($urandom);
            data_in_valid = 1'b1;
            if (cap && fwd < FB) begin
                byte_q.push_back(data_in);
                fwd++;
            end
            tick();
        end
        data_in_valid = 1'b0;
        data_in = 8'd0;
        tick();
        vsync = 1'b0;
        tick();
        if (cap) model_frame_done(fwd);
        repeat (4 + $urandom_range(0, 4)) tick();
    endtask

    // Monitor: every strobe and frame_done is matched against the queues.
    always @(negedge clock) begin
        logic [7:0] eb;
        frame_t     ef;
        if (data_out_valid === 1'b1) begin
            if (byte_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got data_out=%0d, expected no strobe", data_out);
            end else begin
                eb = byte_q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, eb});
            end
        end else begin
            check("idle_data_out", {23'd0, data_out_valid, data_out}, 32'd0);
        end
        if (frame_done === 1'b1) begin
            if (frame_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame_done: got frame_done=1 frame_count=%0d, expected none", frame_count);
            end else begin
                ef = frame_q.pop_front();
                check("frame_byte_count", {17'd0, byte_count}, ef.bytes);
                check("frame_count", {16'd0, frame_count}, ef.fcount);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_dov"},     {31'd0, data_out_valid}, 0);
        check({tag, "_dout"},    {24'd0, data_out}, 0);
        check({tag, "_capt"},    {31'd0, capturing}, 0);
        check({tag, "_fdone"},   {31'd0, frame_done}, 0);
        check({tag, "_timeout"}, {31'd0, timeout}, 0);
        check({tag, "_fcount"},  {16'd0, frame_count}, 0);
        check({tag, "_bcount"},  {17'd0, byte_count}, 0);
    endtask

    initial begin
        bit cap;
        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Stuck in INIT until init_busy has pulsed: arm and a frame are ignored
        arm = 1'b1;
        send_frame(40);
        arm = 1'b0;
        tick();
        check("init_capturing", {31'd0, capturing}, 0);
        init_seq();
        check("post_init_fcount", {16'd0, frame_count}, 0);

        // Skip: frame 1 dropped, frame 2 forwarded, frame 3 dropped
        arm_pulse();
        send_frame(60);
        send_frame(60);
        send_frame(60);
        check("skip_bcount_hold", {17'd0, byte_count}, 60);
        check("skip_fcount", {16'd0, frame_count}, 1);

        // Truncation: 100-byte frame -> 64 forwarded, count saturates and holds
        arm_pulse();
        send_frame(30);
        send_frame(100);
        repeat (5) tick();
        check("trunc_bcount", {17'd0, byte_count}, FB);
        check("trunc_fcount", {16'd0, frame_count}, 2);

        // Frame already in progress at arm is neither skipped nor captured
        vsync = 1'b1;
        repeat (3) tick();
        arm_pulse();
        tick();
        vsync = 1'b0;
        repeat (5) tick();
        send_frame(50);
        send_frame(50);
        check("inprog_fcount", {16'd0, frame_count}, 3);

        // Continuous mode: skip/capture alternate
        continuous = 1'b1;
        model_arm();
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) continuous = 1'b0;
            send_frame($urandom_range(20, 80));
        end
        check("cont_fcount", {16'd0, frame_count}, 6);

        // Back-pressure: arm with buf_ready low does nothing
        buf_ready = 1'b0;
        arm = 1'b1;
        repeat (5) tick();
        send_frame(40);
        check("bp_capturing", {31'd0, capturing}, 0);
        buf_ready = 1'b1;
        model_arm();
        repeat (2) tick();
        arm = 1'b0;
        send_frame(40);
        send_frame(40);
        check("bp_fcount", {16'd0, frame_count}, 7);

        // Reset at byte 50 of a capture
        arm_pulse();
        send_frame(40);
        cap = model_frame_start();
        vsync = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 50; i++) begin
            data_in = 8'($urandom);
            data_in_valid = 1'b1;
            if (cap) byte_q.push_back(data_in);
            tick();
        end
        check("midrst_capturing", {31'd0, capturing}, {31'd0, cap});
        data_in_valid = 1'b0;
        reset = 1'b1;
        tick();
        check_all_zero("midrst");
        reset = 1'b0;
        vsync = 1'b0;
        m_armed = 1'b0;
        m_fc = 0;
        tick();
        init_seq();
        check("post_rst_fcount", {16'd0, frame_count}, 0);

        // Watchdog: armed with vsync held low
        arm_pulse();
        repeat (TO + 100) tick();
        check("watchdog_timeout", {31'd0, timeout}, {31'd0, WD_ON});
        check("watchdog_capturing", {31'd0, capturing}, 0);
        m_armed = 1'b0;

        repeat (10) tick();
        check("bytes_drained", byte_q.size(), 0);
        check("frames_drained", frame_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter SKIP_FRAMES, default 1: whole frames discarded after each arm before capture starts.
REQ-002 Parameter FRAME_BYTES, default 19200: maximum bytes forwarded per captured frame.
REQ-003 Parameter TIMEOUT_CYCLES, default 24000000: watchdog limit in clock cycles.
REQ-004 clock  in  1  single system clock (osc_12m domain); all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 init_busy  in  1  camera I2C init sequencer busy level.
REQ-007 arm  in  1  single-shot capture request; sampled as a level.
REQ-008 continuous  in  1  when 1, re-arm automatically after each frame.
REQ-009 vsync  in  1  frame-active level from the pixel pipeline; rising edge = frame start, falling edge = frame end.
REQ-010 data_in_valid  in  1  pixel byte strobe.
REQ-011 data_in  in  8  pixel byte.
REQ-012 buf_ready  in  1  output buffer can accept a full frame.
REQ-013 data_out_valid  out  1  gated pixel strobe to the frame-end stuffer.
REQ-014 data_out  out  8  gated pixel byte.
REQ-015 capturing  out  1  high while in CAPTURE.
REQ-016 frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-017 timeout  out  1  sticky watchdog flag.
REQ-018 frame_count  out  16  count of completed captured frames; wraps.
REQ-019 byte_count  out  15  bytes forwarded in the current or last frame.

Function
REQ-020 States SHALL be INIT, IDLE, SYNC, CAPTURE, DONE.
REQ-021 INIT SHALL exit to IDLE only after init_busy is seen high and then low.
REQ-022 IDLE SHALL go to SYNC when (arm or continuous) and buf_ready are both 1; the skip counter SHALL load SKIP_FRAMES.
REQ-023 SYNC: each vsync falling edge with skip counter >0 SHALL decrement it; a vsync rising edge with the counter at 0 SHALL enter CAPTURE the next cycle and clear byte_count.
REQ-024 A frame already in progress when SYNC is entered (vsync high) SHALL NOT count as skipped, and SHALL NOT be captured.
REQ-025 CAPTURE SHALL register data_in/data_in_valid to data_out/data_out_valid with 1-cycle latency while byte_count < FRAME_BYTES; any further bytes SHALL be dropped.
REQ-026 Outside CAPTURE, data_out_valid SHALL be 0 and data_out SHALL be 0.
REQ-027 A vsync falling edge in CAPTURE SHALL enter DONE; a valid byte on that same cycle SHALL still be forwarded.
REQ-028 DONE SHALL last one cycle, pulse frame_done, increment frame_count, then return to IDLE.
REQ-029 byte_count SHALL saturate at FRAME_BYTES and hold until the next CAPTURE entry.
REQ-030 Edges SHALL be detected against a 1-cycle registered copy of vsync.

Reset
REQ-031 Reset SHALL force state to INIT and every output to 0, and clear all counters and the registered vsync copy.
REQ-032 Reset asserted mid-CAPTURE SHALL drop data_out_valid on the next edge, with no frame_done pulse.

Configuration
REQ-033 With CAPTURE_SEQ_TIMEOUT_EN defined:
- A cycle counter SHALL clear on each entry to SYNC or CAPTURE.
- When the counter reaches TIMEOUT_CYCLES in SYNC or CAPTURE, timeout SHALL set, and the block SHALL go to IDLE without frame_done.
- timeout SHALL clear only on reset.
REQ-034 Without CAPTURE_SEQ_TIMEOUT_EN, timeout SHALL be constant 0 and no watchdog counter SHALL exist.

Structure
REQ-035 Package capture_seq_pkg SHALL hold the state encoding, byte_count and frame_count widths, and the default parameter constants.
REQ-036 Sub-module vsync_edge_detect SHALL provide registered rise/fall pulses; all other logic SHALL be flat.

Verification
REQ-037 Init: init_busy 0→1 for 10 cycles, then →0 -> INIT→IDLE exactly 1 cycle after the falling edge; no state change before init_busy has been high.
REQ-038 Skip: SKIP_FRAMES=1, arm with vsync low, three 100-byte frames -> frame 1 dropped, frame 2 forwarded (byte_count=100, frame_done once), frame 3 dropped.
REQ-039 Truncation: FRAME_BYTES=64, 100-byte frame -> exactly 64 data_out_valid strobes, byte_count=64, frame_done=1.
REQ-040 Back-pressure: buf_ready=0 with arm=1 -> stays IDLE, no output; buf_ready→1 -> SYNC the next cycle.
REQ-041 Watchdog: macro defined, TIMEOUT_CYCLES=1000, vsync held 0 after arm -> timeout=1 at cycle 1000, state IDLE; macro undefined -> timeout stays 0.
REQ-042 Reset mid-frame: reset at byte 50 of capture -> all outputs 0 next cycle, state INIT, frame_count unchanged (0).
